// File: rtl/boot_mem_pkg.sv
// boot_mem shared types and constants.
// Loader/run state and default geometry.
package boot_mem_pkg;

  localparam int BOOT_ADDR_W = 8;
  localparam int BOOT_DATA_W = 8;
  localparam int BOOT_DEPTH  = 256;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } boot_state_t;

endpackage

// File: rtl/boot_mem_array.sv
// Boot memory storage array.
// One write port, one async read port, no reset.
module boot_mem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // synchronous write
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/boot_mem.sv
// Boot memory: byte-stream loader then core RAM.
// Loader fills from address 0, then releases the core.
module boot_mem
  import boot_mem_pkg::*;
#(
  parameter int ADDR_W = BOOT_ADDR_W,
  parameter int DATA_W = BOOT_DATA_W,
  parameter int DEPTH  = BOOT_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_run,
  output logic [ADDR_W:0]   load_count,
  output logic [DATA_W-1:0] load_sum,
  output logic              load_err
);

  boot_state_t       state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              err_q, err_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // state and loader bookkeeping registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      ptr_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      err_q   <= err_d;
    end
  end

  // next state, pointer, count and checksum
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    err_d   = err_q;
    unique case (state_q)
      LOAD: begin
        if (load_valid) begin
          ptr_d = ptr_q + 1'b1;
          cnt_d = cnt_q + 1'b1;
          sum_d = sum_q + load_data;
          if (load_last) begin
            state_d = RUN;
            err_d   = 1'b0;
          end else if (ptr_q == ADDR_W'(DEPTH - 1)) begin
            state_d = RUN;
            err_d   = 1'b1;
          end
        end
      end
      RUN: begin
        if (load_start) begin
          state_d = LOAD;
          ptr_d   = '0;
          cnt_d   = '0;
          sum_d   = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // write port owned by loader in LOAD, by core in RUN
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = ptr_q;
    mem_wdata = load_data;
    unique case (1'b1)
      (state_q == RUN): begin
        mem_we    = cpu_we;
        mem_waddr = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      default: mem_we = load_valid;
    endcase
  end

  boot_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (cpu_addr),
    .rdata (mem_rdata)
  );

  assign cpu_run    = (state_q == RUN);
  assign load_ready = (state_q == LOAD);
  assign cpu_rdata  = cpu_run ? mem_rdata : '0;
  assign load_count = cnt_q;
  assign load_sum   = sum_q;
  assign load_err   = err_q;

endmodule

// File: tb/tb_boot_mem.sv
// Directed self-checking bench for boot_mem.
// Loader, run-mode access, restart and async reset.
module tb_boot_mem;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_last;
  logic       load_ready;
  logic       load_start;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_we;
  logic [7:0] cpu_rdata;
  logic       cpu_run;
  logic [8:0] load_count;
  logic [7:0] load_sum;
  logic       load_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  boot_mem dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .load_start (load_start),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_we     (cpu_we),
    .cpu_rdata  (cpu_rdata),
    .cpu_run    (cpu_run),
    .load_count (load_count),
    .load_sum   (load_sum),
    .load_err   (load_err)
  );

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d,
                      input logic l);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = l;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic rd(input string tag,
                    input logic [7:0] a,
                    input logic [7:0] exp);
    cpu_addr = a;
    #1;
    chk(tag, {8'h0, cpu_rdata}, {8'h0, exp});
  endtask

  task automatic restart();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    load_last  = 1'b0;
    load_start = 1'b0;
    cpu_addr   = '0;
    cpu_wdata  = '0;
    cpu_we     = 1'b0;
    #3;
    chk("rst_run", {15'h0, cpu_run}, 16'h0);
    chk("rst_cnt", {7'h0, load_count}, 16'h0);
    chk("rst_sum", {8'h0, load_sum}, 16'h0);
    chk("rst_err", {15'h0, load_err}, 16'h0);
    chk("rst_rdata", {8'h0, cpu_rdata}, 16'h0);
    #9;
    rst_n = 1'b1;
    tick();

    // three-byte program
    chk("t1_rdy0", {15'h0, load_ready}, 16'h1);
    send(8'h11, 1'b0);
    chk("t1_rdy1", {15'h0, load_ready}, 16'h1);
    send(8'h22, 1'b0);
    chk("t1_rdy2", {15'h0, load_ready}, 16'h1);
    chk("t1_run_pre", {15'h0, cpu_run}, 16'h0);
    send(8'h33, 1'b1);
    chk("t1_run", {15'h0, cpu_run}, 16'h1);
    chk("t1_rdy_run", {15'h0, load_ready}, 16'h0);
    chk("t1_cnt", {7'h0, load_count}, 16'd3);
    chk("t1_sum", {8'h0, load_sum}, 16'h66);
    chk("t1_err", {15'h0, load_err}, 16'h0);
    rd("t1_rd0", 8'h00, 8'h11);
    rd("t1_rd1", 8'h01, 8'h22);
    rd("t1_rd2", 8'h02, 8'h33);

    // restart, then 256 bytes without last
    restart();
    chk("t2_run0", {15'h0, cpu_run}, 16'h0);
    chk("t2_cnt0", {7'h0, load_count}, 16'h0);
    chk("t2_sum0", {8'h0, load_sum}, 16'h0);
    rd("t2_rd_load", 8'h00, 8'h00);
    for (int i = 0; i < 256; i++) begin
      if (i == 255) begin
        chk("t2_run_pre", {15'h0, cpu_run}, 16'h0);
        chk("t2_cnt_pre", {7'h0, load_count}, 16'd255);
      end
      send(8'(i), 1'b0);
    end
    chk("t2_run", {15'h0, cpu_run}, 16'h1);
    chk("t2_err", {15'h0, load_err}, 16'h1);
    chk("t2_cnt", {7'h0, load_count}, 16'd256);
    chk("t2_sum", {8'h0, load_sum}, 16'h80);
    rd("t2_rd00", 8'h00, 8'h00);
    rd("t2_rdff", 8'hff, 8'hff);
    rd("t2_rd7f", 8'h7f, 8'h7f);

    // run-mode write with read-during-write
    cpu_addr  = 8'h40;
    cpu_wdata = 8'ha5;
    cpu_we    = 1'b1;
    #1;
    chk("t3_old", {8'h0, cpu_rdata}, 16'h40);
    tick();
    cpu_we = 1'b0;
    chk("t3_new", {8'h0, cpu_rdata}, 16'ha5);
    chk("t3_cnt_hold", {7'h0, load_count}, 16'd256);

    // core write ignored in LOAD
    restart();
    cpu_addr  = 8'h40;
    cpu_wdata = 8'h77;
    cpu_we    = 1'b1;
    tick();
    cpu_we = 1'b0;
    chk("t4_cnt_we", {7'h0, load_count}, 16'h0);

    // gapped loader stream
    send(8'haa, 1'b0);
    load_data = 8'hff;
    tick();
    tick();
    chk("t5_cnt_gap", {7'h0, load_count}, 16'd1);
    send(8'hbb, 1'b1);
    chk("t5_run", {15'h0, cpu_run}, 16'h1);
    chk("t5_cnt", {7'h0, load_count}, 16'd2);
    chk("t5_sum", {8'h0, load_sum}, 16'h65);
    chk("t5_err", {15'h0, load_err}, 16'h0);
    rd("t5_rd0", 8'h00, 8'haa);
    rd("t5_rd1", 8'h01, 8'hbb);
    rd("t5_rd2", 8'h02, 8'h02);
    rd("t5_rd40", 8'h40, 8'ha5);

    // restart with simultaneous core write
    cpu_addr   = 8'h10;
    cpu_wdata  = 8'h5a;
    cpu_we     = 1'b1;
    load_start = 1'b1;
    tick();
    cpu_we     = 1'b0;
    chk("t6_run0", {15'h0, cpu_run}, 16'h0);
    chk("t6_cnt0", {7'h0, load_count}, 16'h0);
    chk("t6_sum0", {8'h0, load_sum}, 16'h0);
    send(8'hc3, 1'b0);
    load_start = 1'b0;
    send(8'h3c, 1'b1);
    chk("t6_run", {15'h0, cpu_run}, 16'h1);
    chk("t6_cnt", {7'h0, load_count}, 16'd2);
    chk("t6_sum", {8'h0, load_sum}, 16'hff);
    rd("t6_rd0", 8'h00, 8'hc3);
    rd("t6_rd1", 8'h01, 8'h3c);
    rd("t6_rd10", 8'h10, 8'h5a);

    // async reset mid-load
    restart();
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b0);
    chk("t7_cnt5", {7'h0, load_count}, 16'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_run_rst", {15'h0, cpu_run}, 16'h0);
    chk("t7_cnt_rst", {7'h0, load_count}, 16'h0);
    chk("t7_sum_rst", {8'h0, load_sum}, 16'h0);
    #2;
    rst_n = 1'b1;
    tick();
    send(8'h07, 1'b0);
    send(8'h08, 1'b1);
    chk("t7_cnt", {7'h0, load_count}, 16'd2);
    chk("t7_sum", {8'h0, load_sum}, 16'h0f);
    chk("t7_run", {15'h0, cpu_run}, 16'h1);
    rd("t7_rd0", 8'h00, 8'h07);
    rd("t7_rd2", 8'h02, 8'h03);

    // async reset while running
    #2;
    rst_n = 1'b0;
    #1;
    chk("t8_run_rst", {15'h0, cpu_run}, 16'h0);
    chk("t8_rdata_rst", {8'h0, cpu_rdata}, 16'h0);
    chk("t8_rdy_rst", {15'h0, load_ready}, 16'h1);
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/boot_mem.md
Name: boot_mem

Overview:
- Program/data memory sitting directly downstream of the 8-bit microprocessor core.
- Consumes the core's ram_addr / ram_data / ram_we and produces ram_out.
- Before the core runs, a byte-stream loader port fills memory from address 0. The block then releases the core via cpu_run.
- A restart pulse returns the block to loading for a new program.

Parameters:
- ADDR_W, 8, address width (core address bus width).
- DATA_W, 8, data width.
- DEPTH, 256, number of words; must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock, all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load_valid  input  1  loader byte valid.
- load_data  input  DATA_W  loader byte.
- load_last  input  1  marks final byte of program, qualified by load_valid.
- load_ready  output  1  block accepts loader byte this cycle.
- load_start  input  1  pulse: restart loading (honoured only in RUN).
- cpu_addr  input  ADDR_W  from core ram_addr.
- cpu_wdata  input  DATA_W  from core ram_data.
- cpu_we  input  1  from core ram_we.
- cpu_rdata  output  DATA_W  to core ram_out.
- cpu_run  output  1  core may execute; memory owned by core.
- load_count  output  ADDR_W+1  bytes accepted in current/last load (0..DEPTH).
- load_sum  output  DATA_W  mod-2^DATA_W sum of bytes accepted in current/last load.
- load_err  output  1  last load filled DEPTH bytes without load_last.

Behaviour:
- States: LOAD, RUN.
- Reset (async, rst_n=0): state=LOAD, write pointer=0, load_count=0, load_sum=0, load_err=0, cpu_run=0, load_ready=1 once rst_n releases. cpu_rdata=0. Memory contents are not reset.
- LOAD:
  - load_ready=1.
  - A byte is accepted when load_valid & load_ready at a rising edge. On acceptance: mem[ptr] <= load_data; ptr <= ptr+1; load_count += 1; load_sum += load_data (wraps mod 256).
  - Accepted byte with load_last=1: next state RUN, load_err <= 0.
  - Accepted byte at ptr=DEPTH-1 with load_last=0: next state RUN, load_err <= 1, ptr wraps to 0. No overwrite of address 0 occurs.
  - cpu_we ignored; cpu_rdata=0; cpu_run=0.
- RUN:
  - cpu_run=1 from the cycle after the final byte was accepted (1-cycle latency).
  - load_ready=0; load_valid ignored.
  - Read: cpu_rdata = mem[cpu_addr], combinational (asynchronous read), same cycle.
  - Write: cpu_we=1 at rising edge writes mem[cpu_addr] <= cpu_wdata.
  - Read of the address being written returns old data until the edge, new data after it.
  - load_count, load_sum and load_err hold their values.
- load_start=1 in RUN:
  - Next state LOAD; ptr, load_count and load_sum cleared; load_err cleared; cpu_run=0 next cycle.
  - A cpu_we in the same cycle is still performed, since the state is RUN at that edge.
- load_start in LOAD is ignored. A simultaneous load_start and load byte in LOAD leaves the byte accepted normally.
- Reset mid-load: all loader state cleared as above. Partial bytes remain in memory but are unobservable until RUN.
- A zero-length program is impossible: RUN is entered only after at least one accepted byte.

Decomposition:
- Shared package: state enum {LOAD, RUN}; constants BOOT_ADDR_W=8, BOOT_DATA_W=8, BOOT_DEPTH=256.
- One sub-module, boot_mem_array:
  - DEPTH x DATA_W array, single write port, one asynchronous read port, no reset.
  - Write-port mux (loader vs core) selected by state in boot_mem.
- Control FSM, pointer, counters and checksum live in boot_mem.

Test Plan:
- Reset then stream 0x11,0x22,0x33 (last on 0x33), valid every cycle:
  - load_ready=1 throughout.
  - cpu_run=1 one cycle after 0x33 accepted.
  - load_count=3, load_sum=0x66, load_err=0.
  - cpu_addr=0..2 reads 0x11,0x22,0x33.
- Stream 256 bytes of value i with no load_last:
  - RUN entered after byte 255; load_err=1; load_count=256; load_sum=0x80.
  - cpu_addr=0x00 reads 0x00; cpu_addr=0xFF reads 0xFF.
- In RUN, cpu_we=1, cpu_addr=0x40, cpu_wdata=0xA5:
  - Before the edge, rdata at 0x40 is the old value.
  - After the edge, rdata=0xA5.
  - In LOAD, the same write leaves 0x40 unchanged.
- Loader with gapped load_valid (1,0,0,1,last): only 2 bytes accepted; load_count=2; no extra writes.
- In RUN, pulse load_start together with cpu_we to 0x10 = 0x5A:
  - 0x10 holds 0x5A.
  - cpu_run=0 next cycle; load_count=0; load_sum=0.
  - New stream reloads from address 0.
- Assert rst_n=0 asynchronously mid-load after 5 bytes:
  - cpu_run=0 and load_count=0 immediately, without a clock edge.
  - Reload of 2 bytes yields load_count=2.
